// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and a dual-issue decoder: one write per cycle,
// up to two first-word-fall-through reads per cycle, synchronous flush, fetch-stop threshold.
module inst_fetch_queue #(
  parameter int DATA_W     = 70,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int STOP_LEVEL = 27
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iFREE_REFRESH,
  input  logic              iPREVIOUS_VALID,
  input  logic [DATA_W-1:0] iPREVIOUS_DATA,
  output logic              oPREVIOUS_LOCK,
  output logic              oPREVIOUS_FETCH_STOP,
  output logic              oNEXT0_VALID,
  output logic [DATA_W-1:0] oNEXT0_DATA,
  output logic              oNEXT1_VALID,
  output logic [DATA_W-1:0] oNEXT1_DATA,
  input  logic [1:0]        iNEXT_RD_NUM,
  input  logic              iNEXT_LOCK,
  output logic [ADDR_W:0]   oCOUNT
);

  generate
    if ((DEPTH != (1 << ADDR_W)) || (DEPTH < 4) || (STOP_LEVEL < 1) || (STOP_LEVEL > DEPTH)) begin : gBadParams
      $error("inst_fetch_queue: illegal DEPTH/ADDR_W pairing or STOP_LEVEL out of range");
    end
  endgenerate

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] STOP_CNT = (ADDR_W+1)'(STOP_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] rdPtrNext1;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   rdReq;
  logic [ADDR_W:0]   rdAmt;
  logic [ADDR_W:0]   countNext;
  logic              full;
  logic              wrEn;

  // Handshake: the producer's write is taken when iPREVIOUS_VALID && !oPREVIOUS_LOCK;
  // the decoder sees entries valid when oNEXTn_VALID and takes iNEXT_RD_NUM of them
  // (clamped to 2 and to occupancy) unless iNEXT_LOCK holds the read side.
  always_comb begin
    full       = (count == FULL_CNT);
    wrEn       = iPREVIOUS_VALID && !full;
    rdPtrNext1 = rdPtr + {{(ADDR_W-1){1'b0}}, 1'b1};
    rdReq      = '0;
    case (iNEXT_RD_NUM)
      2'd0:    rdReq = '0;
      2'd1:    rdReq = {{ADDR_W{1'b0}}, 1'b1};
      default: rdReq = {{(ADDR_W-1){1'b0}}, 2'b10};
    endcase
    rdAmt = '0;
    if (!iNEXT_LOCK) begin
      rdAmt = (rdReq > count) ? count : rdReq;
    end
    // Result always lies in 0..DEPTH, so ADDR_W+1 bits hold it exactly.
    countNext = count + {{ADDR_W{1'b0}}, wrEn} - rdAmt;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (iFREE_REFRESH) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + {{(ADDR_W-1){1'b0}}, wrEn};
      rdPtr <= rdPtr + rdAmt[ADDR_W-1:0];
      count <= countNext;
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge iCLOCK) begin
    if (wrEn && !iFREE_REFRESH) begin
      mem[wrPtr] <= iPREVIOUS_DATA;
    end
  end

  assign oNEXT0_DATA          = mem[rdPtr];
  assign oNEXT1_DATA          = mem[rdPtrNext1];
  assign oNEXT0_VALID         = (count >= {{ADDR_W{1'b0}}, 1'b1}) && !iNEXT_LOCK;
  assign oNEXT1_VALID         = (count >= {{(ADDR_W-1){1'b0}}, 2'b10}) && !iNEXT_LOCK;
  assign oPREVIOUS_LOCK       = full;
  assign oPREVIOUS_FETCH_STOP = (count >= STOP_CNT);
  assign oCOUNT               = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue-based reference model predicts the
// outputs each cycle, and a separate monitor compares them a little after the falling edge.
module tb_inst_fetch_queue;

  localparam int DATA_W     = 70;
  localparam int DEPTH      = 32;
  localparam int ADDR_W     = 5;
  localparam int STOP_LEVEL = 27;

  logic              clk;
  logic              iRESET;
  logic              iFREE_REFRESH;
  logic              iPREVIOUS_VALID;
  logic [DATA_W-1:0] iPREVIOUS_DATA;
  logic              oPREVIOUS_LOCK;
  logic              oPREVIOUS_FETCH_STOP;
  logic              oNEXT0_VALID;
  logic [DATA_W-1:0] oNEXT0_DATA;
  logic              oNEXT1_VALID;
  logic [DATA_W-1:0] oNEXT1_DATA;
  logic [1:0]        iNEXT_RD_NUM;
  logic              iNEXT_LOCK;
  logic [ADDR_W:0]   oCOUNT;

  typedef struct packed {
    logic [ADDR_W:0]   cnt;
    logic              v0;
    logic              v1;
    logic              full;
    logic              stop;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] mdl_q[$];
  int                n_cmp = 0;
  int                n_err = 0;

  inst_fetch_queue #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STOP_LEVEL(STOP_LEVEL)
  ) dut (
    .iCLOCK(clk),
    .iRESET(iRESET),
    .iFREE_REFRESH(iFREE_REFRESH),
    .iPREVIOUS_VALID(iPREVIOUS_VALID),
    .iPREVIOUS_DATA(iPREVIOUS_DATA),
    .oPREVIOUS_LOCK(oPREVIOUS_LOCK),
    .oPREVIOUS_FETCH_STOP(oPREVIOUS_FETCH_STOP),
    .oNEXT0_VALID(oNEXT0_VALID),
    .oNEXT0_DATA(oNEXT0_DATA),
    .oNEXT1_VALID(oNEXT1_VALID),
    .oNEXT1_DATA(oNEXT1_DATA),
    .iNEXT_RD_NUM(iNEXT_RD_NUM),
    .iNEXT_LOCK(iNEXT_LOCK),
    .oCOUNT(oCOUNT)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    iRESET          = 1'b1;
    iFREE_REFRESH   = 1'b0;
    iPREVIOUS_VALID = 1'b0;
    iPREVIOUS_DATA  = '0;
    iNEXT_RD_NUM    = 2'd0;
    iNEXT_LOCK      = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  // Driver: one call per clock. Predicts the outputs for the upcoming sample from the
  // model, applies the inputs at the falling edge, then advances the model by one cycle.
  task automatic drive_cycle(input logic rst, input logic flush, input logic wv,
                             input logic [DATA_W-1:0] wd, input logic [1:0] rdn,
                             input logic lk);
    exp_t e;
    int   sz;
    int   req;
    int   rd;
    bit   wr;
    @(negedge clk);
    if (rst) mdl_q.delete();
    sz     = mdl_q.size();
    e.cnt  = (ADDR_W+1)'(sz);
    e.v0   = (sz >= 1) && !lk;
    e.v1   = (sz >= 2) && !lk;
    e.full = (sz == DEPTH);
    e.stop = (sz >= STOP_LEVEL);
    e.d0   = (sz >= 1) ? mdl_q[0] : '0;
    e.d1   = (sz >= 2) ? mdl_q[1] : '0;
    exp_q.push_back(e);
    iRESET          = rst;
    iFREE_REFRESH   = flush;
    iPREVIOUS_VALID = wv;
    iPREVIOUS_DATA  = wd;
    iNEXT_RD_NUM    = rdn;
    iNEXT_LOCK      = lk;
    if (!rst) begin
      if (flush) begin
        mdl_q.delete();
      end else begin
        wr  = wv && (sz < DEPTH);
        req = (rdn > 2) ? 2 : int'(rdn);
        rd  = lk ? 0 : ((req < sz) ? req : sz);
        for (int i = 0; i < rd; i++) void'(mdl_q.pop_front());
        if (wr) mdl_q.push_back(wd);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b0);
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor: samples 1 time unit after each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", DATA_W'(oCOUNT), DATA_W'(e.cnt));
        check("next0_valid", DATA_W'(oNEXT0_VALID), DATA_W'(e.v0));
        check("next1_valid", DATA_W'(oNEXT1_VALID), DATA_W'(e.v1));
        check("prev_lock", DATA_W'(oPREVIOUS_LOCK), DATA_W'(e.full));
        check("fetch_stop", DATA_W'(oPREVIOUS_FETCH_STOP), DATA_W'(e.stop));
        if (e.v0) check("next0_data", oNEXT0_DATA, e.d0);
        if (e.v1) check("next1_data", oNEXT1_DATA, e.d1);
      end
    end
  end

  // Stimulus
  initial begin
    // Reset then idle
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0);
    idle(2);
    // Reset held 3 cycles in the middle of a write burst, applied between edges
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    idle(2);

    // Fill to full; the 33rd write must be dropped
    for (int i = 0; i < 33; i++) drive_cycle(1'b0, 1'b0, 1'b1, DATA_W'(i), 2'd0, 1'b0);
    idle(2);
    while (mdl_q.size() > 0) drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b0);
    idle(1);

    // Dual drain across the pointer wrap
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd1, 1'b0);
    for (int i = 0; i < 32; i++) drive_cycle(1'b0, 1'b0, 1'b1, DATA_W'(32'h100 + i), 2'd0, 1'b0);
    for (int i = 0; i < 17; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b0);

    // Truncation with one entry: request 2, then 3
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd3, 1'b0);
    idle(2);

    // Write plus 2-read at count 2
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd2, 1'b0);
    idle(1);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd1, 1'b0);

    // Decoder lock at count 5
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd2, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b0);

    // Flush beats a simultaneous write and 2-read
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, DATA_W'(70'h3DEAD), 2'd2, 1'b0);
    idle(2);
    drive_cycle(1'b0, 1'b0, 1'b1, rnd_data(), 2'd0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 2'd2, 1'b0);
    idle(1);

    // Randomized: write-heavy phase then read-heavy phase
    for (int i = 0; i < 1200; i++) begin
      logic fl;
      logic wv;
      logic lk;
      logic [1:0] rn;
      fl = ($urandom_range(0, 79) == 0);
      lk = ($urandom_range(0, 4) == 0);
      rn = 2'($urandom_range(0, 3));
      if (i < 600) wv = ($urandom_range(0, 9) != 0);
      else         wv = ($urandom_range(0, 9) < 4);
      if (i < 600 && $urandom_range(0, 1) == 0) rn = 2'd0;
      drive_cycle(1'b0, fl, wv, rnd_data(), rn, lk);
    end
    // Random asynchronous reset mid-traffic
    drive_cycle(1'b1, 1'b0, 1'b1, rnd_data(), 2'd1, 1'b0);
    idle(3);

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
